// File: rtl/trigger_capture.sv
// Acquisition front end: fills a circular sample buffer, waits for an edge trigger
// with hysteresis (or an auto-timeout), then captures the post-trigger samples.
module trigger_capture #(
  parameter int BUFFER_LEN   = 512,
  parameter int ADDR_W       = 9,
  parameter int PRE_TRIG     = 240,
  parameter int HYST         = 4,
  parameter int AUTO_TIMEOUT = 1048576,
  parameter int TO_W         = 21
) (
  input  logic              pll_clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [7:0]        i_adc_data,
  input  logic [7:0]        i_level,
  input  logic              i_edge,
  input  logic              i_auto,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [7:0]        o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_trig_addr,
  output logic              o_auto_fired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam int POST_LEN = BUFFER_LEN - PRE_TRIG - 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_arm;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_auto_fired;

  logic [8:0] w_lvl9;
  logic [8:0] w_smp9;
  logic [8:0] w_lo;
  logic [8:0] w_hi_raw;
  logic [8:0] w_hi;
  logic       w_arm_cond;
  logic       w_hit;
  logic       w_timeout;

  // Hysteresis thresholds are clamped to the 0..255 code range.
  assign w_lvl9     = {1'b0, i_level};
  assign w_smp9     = {1'b0, i_adc_data};
  assign w_lo       = (w_lvl9 >= 9'(HYST)) ? (w_lvl9 - 9'(HYST)) : 9'd0;
  assign w_hi_raw   = w_lvl9 + 9'(HYST);
  assign w_hi       = (w_hi_raw > 9'd255) ? 9'd255 : w_hi_raw;
  assign w_arm_cond = i_edge ? (w_smp9 > w_hi) : (w_smp9 < w_lo);
  // A trigger needs the arm flag from earlier samples, not the current one.
  assign w_hit      = r_arm && (i_edge ? (w_smp9 <= w_lvl9) : (w_smp9 >= w_lvl9));
  assign w_timeout  = i_auto && (r_to_cnt == TO_LAST);

  always_ff @(posedge pll_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_to_cnt     <= '0;
      r_arm        <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_trig_addr  <= '0;
      r_auto_fired <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_state      <= S_PREFILL;
            r_ptr        <= '0;
            r_pre_cnt    <= '0;
            r_arm        <= 1'b0;
            r_auto_fired <= 1'b0;
            r_busy       <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_PREFILL, S_ARMED, S_POST: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            // Sample of this cycle lands on the RAM port next cycle at the current pointer.
            r_we    <= 1'b1;
            r_waddr <= r_ptr;
            r_wdata <= i_adc_data;
            r_ptr   <= r_ptr + 1'b1;
            if (r_state != S_POST && w_arm_cond) begin
              r_arm <= 1'b1;
            end
            if (r_state == S_PREFILL) begin
              if (r_pre_cnt == PRE_LAST) begin
                r_state  <= S_ARMED;
                r_to_cnt <= '0;
              end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
              end
            end else if (r_state == S_ARMED) begin
              if (w_hit || w_timeout) begin
                r_state      <= S_POST;
                r_trig_addr  <= r_ptr;
                r_auto_fired <= !w_hit;
                r_post_cnt   <= '0;
              end else if (r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + 1'b1;
              end
            end else begin
              if (r_post_cnt == POST_LAST) begin
                r_state <= S_DONE;
              end else begin
                r_post_cnt <= r_post_cnt + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          // The done pulse follows the final write, with the write enable already low.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_we         = r_we;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_trig_addr  = r_trig_addr;
  assign o_auto_fired = r_auto_fired;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: ramp, falling-edge hysteresis, auto-timeout,
// stop, start/stop collisions and mid-capture reset.
module tb_trigger_capture;

  logic       pll_clk;
  logic       rst;
  logic       i_start;
  logic       i_stop;
  logic [7:0] i_adc_data;
  logic [7:0] i_level;
  logic       i_edge;
  logic       i_auto;
  logic       o_we;
  logic [8:0] o_waddr;
  logic [7:0] o_wdata;
  logic       o_busy;
  logic       o_done;
  logic [8:0] o_trig_addr;
  logic       o_auto_fired;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  bit track_wr = 1'b0;
  logic [7:0] mem [512];
  logic [31:0] exp_q[$];

  trigger_capture #(.AUTO_TIMEOUT(64)) dut (
    .pll_clk      (pll_clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_adc_data   (i_adc_data),
    .i_level      (i_level),
    .i_edge       (i_edge),
    .i_auto       (i_auto),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_trig_addr  (o_trig_addr),
    .o_auto_fired (o_auto_fired)
  );

  // clock / watchdog
  initial pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM model / write scoreboard, sampled on the falling edge
  always @(negedge pll_clk) begin
    if (o_we) begin
      we_cnt++;
      mem[o_waddr] = o_wdata;
      if (track_wr) begin
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("wr", {15'd0, o_waddr, o_wdata}, e);
      end
    end
    if (o_done) done_cnt++;
  end

  // driver: input applied just after a falling edge, outputs read one cycle later
  task automatic cycle(input logic [7:0] d);
    i_adc_data = d;
    @(negedge pll_clk);
    #1;
  endtask

  task automatic start_capture();
    i_start = 1'b1;
    cycle(8'd0);
    i_start = 1'b0;
  endtask

  // Ramp aligned so the first ARMED sample (index 240) is 128.
  task automatic run_ramp_capture(input bit start_in_post);
    logic [7:0] d;
    we_cnt = 0;
    done_cnt = 0;
    exp_q.delete();
    for (int k = 0; k < 512; k++) begin
      d = 8'(144 + k);
      exp_q.push_back({15'd0, 9'(k), d});
    end
    track_wr = 1'b1;
    i_level = 8'd128;
    i_edge = 1'b0;
    i_auto = 1'b0;
    start_capture();
    chk("ramp_busy_start", {31'd0, o_busy}, 32'd1);
    chk("ramp_we_start", {31'd0, o_we}, 32'd0);
    for (int k = 0; k < 512; k++) begin
      d = 8'(144 + k);
      if (start_in_post && k == 300) i_start = 1'b1;
      cycle(d);
      i_start = 1'b0;
      if (k == 0) chk("ramp_first_addr", {23'd0, o_waddr}, 32'd0);
      if (k == 240) chk("ramp_trig_addr", {23'd0, o_trig_addr}, 32'd240);
    end
    chk("ramp_last_addr", {23'd0, o_waddr}, 32'd511);
    chk("ramp_last_we", {31'd0, o_we}, 32'd1);
    cycle(8'd0);
    chk("ramp_done", {31'd0, o_done}, 32'd1);
    chk("ramp_done_we", {31'd0, o_we}, 32'd0);
    chk("ramp_done_busy", {31'd0, o_busy}, 32'd0);
    cycle(8'd0);
    chk("ramp_done_width", {31'd0, o_done}, 32'd0);
    chk("ramp_we_count", 32'(we_cnt), 32'd512);
    chk("ramp_done_count", 32'(done_cnt), 32'd1);
    chk("ramp_q_left", 32'(exp_q.size()), 32'd0);
    chk("ramp_mem_trig", {24'd0, mem[240]}, 32'd128);
    chk("ramp_auto", {31'd0, o_auto_fired}, 32'd0);
    track_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_stop = 1'b0;
    i_adc_data = 8'd0;
    i_level = 8'd128;
    i_edge = 1'b0;
    i_auto = 1'b0;
    repeat (3) @(negedge pll_clk);
    #1;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_we", {31'd0, o_we}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_trig", {23'd0, o_trig_addr}, 32'd0);
    rst = 1'b0;
    cycle(8'd0);

    // rising edge on a ramp
    run_ramp_capture(1'b0);

    // falling edge, level 100: 102 never arms, 110 arms, then 90 fires
    we_cnt = 0;
    done_cnt = 0;
    i_level = 8'd100;
    i_edge = 1'b1;
    start_capture();
    for (int k = 0; k < 270; k++) cycle((k < 260) ? 8'd102 : 8'd90);
    chk("fall_busy_noarm", {31'd0, o_busy}, 32'd1);
    chk("fall_trig_old", {23'd0, o_trig_addr}, 32'd240);
    chk("fall_no_done", 32'(done_cnt), 32'd0);
    cycle(8'd110);
    cycle(8'd90);
    chk("fall_trig_addr", {23'd0, o_trig_addr}, 32'd271);
    for (int k = 272; k < 543; k++) cycle(8'd90);
    chk("fall_last_addr", {23'd0, o_waddr}, 32'd30);
    cycle(8'd90);
    chk("fall_done", {31'd0, o_done}, 32'd1);
    chk("fall_we_count", 32'(we_cnt), 32'd543);
    chk("fall_mem_trig", {24'd0, mem[271]}, 32'd90);
    chk("fall_auto", {31'd0, o_auto_fired}, 32'd0);

    // auto-timeout fires on the 64th ARMED sample
    we_cnt = 0;
    done_cnt = 0;
    i_level = 8'd128;
    i_edge = 1'b0;
    i_auto = 1'b1;
    start_capture();
    for (int k = 0; k < 303; k++) cycle(8'd50);
    chk("auto_pre_trig", {23'd0, o_trig_addr}, 32'd271);
    chk("auto_pre_flag", {31'd0, o_auto_fired}, 32'd0);
    cycle(8'd50);
    chk("auto_trig_addr", {23'd0, o_trig_addr}, 32'd303);
    chk("auto_flag", {31'd0, o_auto_fired}, 32'd1);
    for (int k = 304; k < 575; k++) cycle(8'd50);
    chk("auto_last_addr", {23'd0, o_waddr}, 32'd62);
    cycle(8'd50);
    chk("auto_done", {31'd0, o_done}, 32'd1);
    chk("auto_flag_hold", {31'd0, o_auto_fired}, 32'd1);

    // no auto: stays busy, then stop
    we_cnt = 0;
    done_cnt = 0;
    i_auto = 1'b0;
    start_capture();
    chk("stop_flag_clr", {31'd0, o_auto_fired}, 32'd0);
    for (int k = 0; k < 600; k++) cycle(8'd50);
    chk("stop_busy_long", {31'd0, o_busy}, 32'd1);
    chk("stop_no_done", 32'(done_cnt), 32'd0);
    i_stop = 1'b1;
    cycle(8'd50);
    i_stop = 1'b0;
    chk("stop_busy", {31'd0, o_busy}, 32'd0);
    chk("stop_we", {31'd0, o_we}, 32'd0);
    chk("stop_done", {31'd0, o_done}, 32'd0);
    repeat (5) cycle(8'd50);
    chk("stop_we_count", 32'(we_cnt), 32'd600);
    chk("stop_done_count", 32'(done_cnt), 32'd0);
    chk("stop_trig_keep", {23'd0, o_trig_addr}, 32'd303);

    // start and stop together in IDLE
    we_cnt = 0;
    i_start = 1'b1;
    i_stop = 1'b1;
    cycle(8'd50);
    i_start = 1'b0;
    i_stop = 1'b0;
    chk("ss_busy", {31'd0, o_busy}, 32'd0);
    repeat (3) cycle(8'd50);
    chk("ss_we_count", 32'(we_cnt), 32'd0);

    // start during POST is ignored
    run_ramp_capture(1'b1);

    // reset while ARMED
    start_capture();
    for (int k = 0; k < 260; k++) cycle(8'd50);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_we", {31'd0, o_we}, 32'd0);
    chk("arst_waddr", {23'd0, o_waddr}, 32'd0);
    chk("arst_wdata", {24'd0, o_wdata}, 32'd0);
    chk("arst_done", {31'd0, o_done}, 32'd0);
    chk("arst_trig", {23'd0, o_trig_addr}, 32'd0);
    chk("arst_auto", {31'd0, o_auto_fired}, 32'd0);
    repeat (2) @(negedge pll_clk);
    #1;
    rst = 1'b0;
    cycle(8'd0);
    run_ramp_capture(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
